// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e     : arbiter FSM states
//   CTRL_*      : encodings of the memory ctrlMEM bus ([1] = read, [0] = write)
//   NUM_PORTS   : number of requesters sharing the memory
//   addr_legal  : word-aligned and inside the memory's byte range
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [1:0] CTRL_RD   = 2'b10;
  localparam logic [1:0] CTRL_WR   = 2'b01;
  localparam logic [1:0] CTRL_IDLE = 2'b00;

  localparam int unsigned NUM_PORTS = 2;

  // Compared at 34 bits so large MEM_WORDS values cannot wrap the limit.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned mem_words);
    logic [33:0] limit;
    limit = 34'(mem_words) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational two-way request picker.
//   req_i          : per-port request
//   last_grant_i   : port granted most recently
//   mode_i         : 0 = round-robin, 1 = fixed priority (port 0 wins)
//   winner_valid_o : at least one port requesting
//   winner_id_o    : chosen port
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_grant_i,
  input  logic                 mode_i,
  output logic                 winner_valid_o,
  output logic                 winner_id_o
);

  always_comb begin
    winner_valid_o = |req_i;
    winner_id_o    = 1'b0;
    case (req_i)
      2'b01:   winner_id_o = 1'b0;
      2'b10:   winner_id_o = 1'b1;
      // Contention: fixed priority favours port 0, round-robin favours
      // whichever port was not served last.
      2'b11:   winner_id_o = mode_i ? 1'b0 : ~last_grant_i;
      default: winner_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage
// (port 0) and the debug/program loader (port 1). One access at a time:
// IDLE (arbitrate, latch) -> ACCESS (memory strobe, 1 cycle) -> DONE
// (ack/err pulse, 1 cycle). Illegal addresses go IDLE -> DONE with err set
// and never touch the memory. All outputs are registered.
//   i_clk, i_reset_n        : clock, synchronous active-low reset
//   i_req, i_we             : per-port request / write enable
//   i_addr0/1, i_wdata0/1   : per-port byte address / write data
//   o_ack, o_err            : one-cycle completion / error pulse to the winner
//   o_rdata                 : read data, valid in a read-ack cycle
//   o_busy                  : high in ACCESS and DONE
//   o_memAddr, o_writeData  : memory address / write data
//   o_ctrlMEM               : memory strobe, [1] = read, [0] = write
//   i_readData              : memory read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_we,
  input  logic [31:0]          i_addr0,
  input  logic [31:0]          i_addr1,
  input  logic [31:0]          i_wdata0,
  input  logic [31:0]          i_wdata1,
  output logic [NUM_PORTS-1:0] o_ack,
  output logic [NUM_PORTS-1:0] o_err,
  output logic [31:0]          o_rdata,
  output logic                 o_busy,
  output logic [31:0]          o_memAddr,
  output logic [31:0]          o_writeData,
  output logic [1:0]           o_ctrlMEM,
  input  logic [31:0]          i_readData
);

  localparam logic FIXED_PRIO = (ARB_MODE != 0);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 id_q, id_d;
  logic                 we_q, we_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic [31:0]          maddr_q, maddr_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [1:0]           ctrl_q, ctrl_d;

  logic                 win_valid;
  logic                 win_id;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_we;

  mem_arb_rr u_pick (
    .req_i          (i_req),
    .last_grant_i   (last_q),
    .mode_i         (FIXED_PRIO),
    .winner_valid_o (win_valid),
    .winner_id_o    (win_id)
  );

  always_comb begin
    sel_addr  = win_id ? i_addr1  : i_addr0;
    sel_wdata = win_id ? i_wdata1 : i_wdata0;
    sel_we    = i_we[win_id];
  end

  // Memory-side and requester-side outputs are computed here as next-state
  // values so that each one is a plain register.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdat_d  = wdat_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = '0;
    busy_d  = 1'b0;
    ctrl_d  = CTRL_IDLE;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          id_d   = win_id;
          last_d = win_id;
          we_d   = sel_we;
          busy_d = 1'b1;
          if (addr_legal(sel_addr, MEM_WORDS)) begin
            state_d = ACCESS;
            maddr_d = sel_addr;
            wdat_d  = sel_wdata;
            ctrl_d  = sel_we ? CTRL_WR : CTRL_RD;
          end else begin
            // Error response: skip ACCESS, pulse ack+err on entering DONE.
            state_d        = DONE;
            ack_d[win_id]  = 1'b1;
            err_d[win_id]  = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d     = DONE;
        busy_d      = 1'b1;
        ack_d[id_q] = 1'b1;
        rdata_d     = we_q ? '0 : i_readData;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // makes port 0 the first contention winner
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      maddr_q <= '0;
      wdat_q  <= '0;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      maddr_q <= maddr_d;
      wdat_q  <= wdat_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_memAddr   = maddr_q;
  assign o_writeData = wdat_q;
  assign o_ctrlMEM   = ctrl_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin and fixed priority)
// receive identical directed requester tables. Each instance has its own
// memory device and a transaction-level model that schedules the expected
// output cycles; a per-instance checker compares every cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned MW = 2048;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  ctrl;
    logic [31:0] maddr;
    logic [31:0] wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [31:0] a0    [2];
  logic [31:0] a1    [2];
  logic [31:0] wd0   [2];
  logic [31:0] wd1   [2];
  logic [1:0]  ack   [2];
  logic [1:0]  err   [2];
  logic [31:0] rdata [2];
  logic        busy  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [1:0]  ctrl  [2];
  logic [31:0] rdmem [2];

  logic [31:0] dmem [2][MW];  // memory device contents
  logic [31:0] mmem [2][MW];  // model's view of memory

  // Requester tables (same for both instances)
  logic        tb_we   [2][8];
  logic [31:0] tb_addr [2][8];
  logic [31:0] tb_wd   [2][8];
  int          cnt [2];
  int          idx [2][2];
  bit          ack_seen [2][2];

  // Ack log per instance
  int          log_port [2][32];
  int          log_cyc  [2][32];
  logic [31:0] log_rd   [2][32];
  logic        log_err  [2][32];
  int          log_n [2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  for (genvar m = 0; m < 2; m++) begin : g_inst
    mem_arbiter #(.ARB_MODE(m), .MEM_WORDS(MW)) u_dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_req       (req[m]),
      .i_we        (we[m]),
      .i_addr0     (a0[m]),
      .i_addr1     (a1[m]),
      .i_wdata0    (wd0[m]),
      .i_wdata1    (wd1[m]),
      .o_ack       (ack[m]),
      .o_err       (err[m]),
      .o_rdata     (rdata[m]),
      .o_busy      (busy[m]),
      .o_memAddr   (maddr[m]),
      .o_writeData (mwd[m]),
      .o_ctrlMEM   (ctrl[m]),
      .i_readData  (rdmem[m])
    );

    // Memory device: read data on negedge, write commit on posedge.
    bit          dev_wp;
    logic [10:0] dev_wi;
    logic [31:0] dev_wv;
    initial forever begin
      @(negedge clk);
      if (ctrl[m] == 2'b10) rdmem[m] = dmem[m][maddr[m][12:2]];
      dev_wp = (ctrl[m] == 2'b01);
      dev_wi = maddr[m][12:2];
      dev_wv = mwd[m];
    end
    initial forever begin
      @(posedge clk);
      if (dev_wp) begin
        dmem[m][dev_wi] = dev_wv;
        dev_wp = 1'b0;
      end
    end

    // Transaction model: on each sampling edge k, schedule the expected
    // outputs for the cycles after edges k and k+1.
    obs_t        exp_s [4];
    obs_t        m_e, g_got, g_exp;
    int          k, free_k, wr_k, w;
    bit          last;
    logic [10:0] wr_i;
    logic [31:0] wr_v, ma, mw;
    logic        mwe;
    initial begin
      k = 0; free_k = 0; wr_k = -1; last = 1'b1;
      for (int j = 0; j < 4; j++) exp_s[j] = '0;
      forever begin
        @(posedge clk);
        k++;
        if (wr_k == k) begin
          mmem[m][wr_i] = wr_v;
          wr_k = -1;
        end
        if (!rst_n) begin
          for (int j = 0; j < 3; j++) exp_s[(k + j) % 4] = '0;
          last = 1'b1; free_k = k + 1; wr_k = -1;
        end else if (k >= free_k && req[m] != 2'b00) begin
          if (req[m] == 2'b01) w = 0;
          else if (req[m] == 2'b10) w = 1;
          else if (m == 1) w = 0;
          else w = last ? 0 : 1;
          last = (w == 1);
          ma  = (w == 1) ? a1[m] : a0[m];
          mw  = (w == 1) ? wd1[m] : wd0[m];
          mwe = we[m][w];
          m_e = '0;
          m_e.busy = 1'b1;
          m_e.ack[w] = 1'b1;
          if (ma[1:0] != 2'b00 || ma >= 32'(4 * MW)) begin
            m_e.err[w] = 1'b1;
            exp_s[k % 4] = m_e;
            free_k = k + 2;
          end else begin
            m_e.rdata = mwe ? 32'h0 : mmem[m][ma[12:2]];
            exp_s[(k + 1) % 4] = m_e;
            m_e = '0;
            m_e.busy  = 1'b1;
            m_e.ctrl  = mwe ? 2'b01 : 2'b10;
            m_e.maddr = ma;
            m_e.wdata = mw;
            exp_s[k % 4] = m_e;
            if (mwe) begin
              wr_k = k + 1; wr_i = ma[12:2]; wr_v = mw;
            end
            free_k = k + 3;
          end
        end
      end
    end

    // Per-cycle compare and ack logging.
    initial forever begin
      @(negedge clk);
      if (k > 0) begin
        g_got.ack   = ack[m];
        g_got.err   = err[m];
        g_got.rdata = rdata[m];
        g_got.busy  = busy[m];
        g_got.ctrl  = ctrl[m];
        g_got.maddr = maddr[m];
        g_got.wdata = mwd[m];
        g_exp = exp_s[k % 4];
        exp_s[k % 4] = '0;
        if (g_exp.ctrl == 2'b00) begin
          g_got.maddr = '0;
          g_got.wdata = '0;
        end
        chk($sformatf("outputs inst%0d cyc%0d", m, k), 128'(g_got), 128'(g_exp));
        for (int p = 0; p < 2; p++) begin
          if (ack[m][p]) begin
            ack_seen[m][p] = 1'b1;
            if (log_n[m] < 32) begin
              log_port[m][log_n[m]] = p;
              log_cyc[m][log_n[m]]  = k;
              log_rd[m][log_n[m]]   = rdata[m];
              log_err[m][log_n[m]]  = err[m][p];
              log_n[m]++;
            end
          end
        end
      end
    end
  end

  // Requester driver: holds req until the ack cycle ends, then moves on.
  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; we[m] = '0; a0[m] = '0; a1[m] = '0; wd0[m] = '0; wd1[m] = '0;
      rdmem[m] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < 2; p++) begin
          if (ack_seen[m][p]) begin
            idx[m][p]++;
            ack_seen[m][p] = 1'b0;
          end
          if (idx[m][p] < cnt[p]) begin
            req[m][p] = 1'b1;
            we[m][p]  = tb_we[p][idx[m][p]];
            if (p == 0) begin
              a0[m] = tb_addr[p][idx[m][p]]; wd0[m] = tb_wd[p][idx[m][p]];
            end else begin
              a1[m] = tb_addr[p][idx[m][p]]; wd1[m] = tb_wd[p][idx[m][p]];
            end
          end else begin
            req[m][p] = 1'b0;
            we[m][p]  = 1'b0;
          end
        end
      end
    end
  end

  task automatic new_phase();
    cnt[0] = 0; cnt[1] = 0;
    for (int m = 0; m < 2; m++) begin
      log_n[m] = 0;
      for (int p = 0; p < 2; p++) idx[m][p] = 0;
    end
  endtask

  task automatic add_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    tb_we[p][cnt[p]]   = w;
    tb_addr[p][cnt[p]] = a;
    tb_wd[p][cnt[p]]   = d;
    cnt[p]++;
  endtask

  task automatic run_phase(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = 1'b1;
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++)
          if (idx[m][p] < cnt[p]) done = 1'b0;
    end
    chk("phase_done", 128'(done), 128'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit       seen;
    bit [5:0] order;
    cnt[0] = 0; cnt[1] = 0;
    for (int m = 0; m < 2; m++) begin
      log_n[m] = 0;
      for (int p = 0; p < 2; p++) begin
        idx[m][p] = 0; ack_seen[m][p] = 1'b0;
      end
      for (int i = 0; i < int'(MW); i++) begin
        dmem[m][i] = '0; mmem[m][i] = '0;
      end
      dmem[m][4] = 32'hDEADBEEF;
      mmem[m][4] = 32'hDEADBEEF;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("reset_ack",  128'(ack[m]),  128'(0));
      chk("reset_ctrl", 128'(ctrl[m]), 128'(0));
      chk("reset_busy", 128'(busy[m]), 128'(0));
    end
    rst_n = 1'b1;

    // Single read of word 4
    new_phase();
    add_txn(0, 1'b0, 32'h0000_0010, 32'h0);
    run_phase(30);
    for (int m = 0; m < 2; m++) begin
      chk("single_read_port", 128'(log_port[m][0]), 128'(0));
      chk("single_read_data", 128'(log_rd[m][0]),   128'(32'hDEADBEEF));
    end

    // Port 1 write then read back
    new_phase();
    add_txn(1, 1'b1, 32'h0000_0100, 32'h1234_5678);
    add_txn(1, 1'b0, 32'h0000_0100, 32'h0);
    run_phase(30);
    for (int m = 0; m < 2; m++) begin
      chk("wr_rd_port",  128'(log_port[m][1]), 128'(1));
      chk("wr_rd_err",   128'({log_err[m][0], log_err[m][1]}), 128'(0));
      chk("wr_rd_data",  128'(log_rd[m][1]),  128'(32'h1234_5678));
    end

    // Contention: three transactions per port, requests held throughout
    new_phase();
    for (int i = 0; i < 3; i++) begin
      add_txn(0, 1'b0, 32'h0000_0010 + 32'(4 * i), 32'h0);
      add_txn(1, 1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0);
    end
    run_phase(60);
    for (int m = 0; m < 2; m++) begin
      order = '0;
      for (int i = 0; i < 6; i++) order[i] = (log_port[m][i] == 1);
      chk($sformatf("grant_order inst%0d", m), 128'(order),
          (m == 0) ? 128'(6'b101010) : 128'(6'b111000));
      for (int i = 1; i < 6; i++)
        chk("ack_spacing", 128'(log_cyc[m][i] - log_cyc[m][i-1]), 128'(3));
    end

    // Error paths plus the last legal word
    new_phase();
    add_txn(0, 1'b0, 32'h0000_0002, 32'h0);
    add_txn(0, 1'b1, 32'h0000_2000, 32'hAAAA_5555);
    add_txn(0, 1'b0, 32'h0000_1FFC, 32'h0);
    run_phase(40);
    for (int m = 0; m < 2; m++) begin
      chk("err_flags", 128'({log_err[m][2], log_err[m][1], log_err[m][0]}), 128'(3'b011));
      chk("err_spacing", 128'(log_cyc[m][1] - log_cyc[m][0]), 128'(2));
      chk("err_to_good_spacing", 128'(log_cyc[m][2] - log_cyc[m][1]), 128'(3));
    end

    // Reset in the middle of ACCESS
    new_phase();
    add_txn(0, 1'b0, 32'h0000_0010, 32'h0);
    add_txn(1, 1'b0, 32'h0000_0100, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ctrl[0] != 2'b00 && ctrl[1] != 2'b00) seen = 1'b1;
    end
    chk("reach_access", 128'(seen), 128'(1));
    rst_n = 1'b0;
    log_n[0] = 0; log_n[1] = 0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("abort_ctrl", 128'(ctrl[m]), 128'(0));
      chk("abort_ack",  128'(ack[m]),  128'(0));
      chk("abort_busy", 128'(busy[m]), 128'(0));
    end
    rst_n = 1'b1;
    run_phase(40);
    for (int m = 0; m < 2; m++) begin
      chk("post_reset_first",  128'(log_port[m][0]), 128'(0));
      chk("post_reset_second", 128'(log_port[m][1]), 128'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
